mgmt_qspi_bridge: RTL
=====================

Name: mgmt_qspi_bridge

Overview:
- Sits between the QSPI device-mode byte PHY and the management register interface.
- Turns a framed byte stream (2-byte address, then data) into rd_en/wr_en register-bus cycles. Address auto-increments per byte.
- On reads, prefetches register bytes into a one-byte TX holding register that the PHY shifts out.
- Tracks aborted reads and TX underruns so the downstream bus is never violated.

Parameters:
RD_TIMEOUT, 1024, clk cycles to wait for rd_valid before returning 8'hEE and releasing the bus
CNT_WIDTH, 8, width of saturating underrun/timeout counters

Ports:
clk  in  1  management core clock
rst_n  in  1  reset; synchronous, active-low
qspi_start  in  1  one-cycle pulse: CS asserted, new transaction
qspi_end  in  1  one-cycle pulse: CS deasserted
qspi_rx_valid  in  1  received byte strobe
qspi_rx_data  in  8  received byte
qspi_tx_ready  in  1  pulse: PHY latched qspi_tx_data, wants next byte
qspi_tx_valid  out  1  holding register contains fresh read data
qspi_tx_data  out  8  byte for PHY to shift out
rd_en  out  1  one-cycle read request
rd_addr  out  16  read address, held stable until rd_valid
rd_valid  in  1  read data valid
rd_data  in  8  read data
wr_en  out  1  one-cycle write strobe
wr_addr  out  16  write address
wr_data  out  8  write data
underrun_count  out  CNT_WIDTH  tx_ready seen while !qspi_tx_valid, saturating
timeout_count  out  CNT_WIDTH  reads terminated by RD_TIMEOUT, saturating

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs go to 0, including both counters and qspi_tx_data.
  - State=IDLE; rd_busy=0; rd_discard=0.
  - Reset mid-read abandons the read without waiting for rd_valid.
- States: IDLE, ADDR_HI, ADDR_LO, WRITE, READ.
- qspi_start in any state -> ADDR_HI. It clears qspi_tx_valid. If rd_busy, it sets rd_discard.
- qspi_end in any state -> IDLE. It clears qspi_tx_valid. If rd_busy, it sets rd_discard.
- If start and end arrive in the same cycle, start wins.
- ADDR_HI: rx byte -> addr[15:8] -> ADDR_LO.
- ADDR_LO: rx byte -> addr[7:0].
  - bit15=1: read; -> READ and request a read.
  - bit15=0: write; -> WRITE.
  - Bit 15 is the R/W flag only. rd_addr[15] and wr_addr[15] are always 0.
- WRITE: each rx byte produces a wr_en pulse on the next cycle, with wr_addr=addr and wr_data=byte. addr then increments.
- Address increment is 15-bit: 0x7FFF -> 0x0000.
- Read request:
  - Issued only when !rd_busy: rd_en=1 for one cycle, rd_addr=addr, rd_busy=1.
  - If rd_busy (a discarded read is still draining), the request is deferred until rd_busy falls.
- rd_valid while rd_busy:
  - rd_busy=0 and the timer clears.
  - If rd_discard: data dropped and rd_discard=0.
  - Otherwise: qspi_tx_data<=rd_data, qspi_tx_valid<=1, addr increments.
  - rd_valid while !rd_busy is ignored.
- Timeout: the timer counts while rd_busy. When it reaches RD_TIMEOUT:
  - Treat as rd_valid with data 8'hEE.
  - timeout_count increments.
  - rd_addr is released.
- READ and qspi_tx_ready with qspi_tx_valid=1: qspi_tx_valid<=0, and a read of the incremented addr is requested in the same cycle.
- qspi_tx_ready with qspi_tx_valid=0 (any state):
  - underrun_count increments, saturating at all-ones.
  - qspi_tx_data is unchanged, so the PHY resends the stale byte.
  - No new read is issued; the pending read continues.
- qspi_rx_valid in READ, or in IDLE: ignored (dummy/turnaround bytes).
- Latency, from ADDR_LO byte to rd_en: 1 cycle. From rd_valid to qspi_tx_valid: 1 cycle.
- At most one read is outstanding. rd_addr never changes while rd_busy.

Test Plan:
- Write burst: start, bytes 0x40,0x02,0xAB,0xCD, end -> wr_en pulses at 0x4002=0xAB and 0x4003=0xCD; no rd_en.
- Read burst:
  - Stimulus: start, 0x80,0x00; downstream returns 0x12 after 1 cycle; tx_ready x3.
  - Required: qspi_tx_data 0x12 from addr 0x0000, then 0x0001, 0x0002, 0x0003 requested in order.
  - Required: rd_addr[15]=0 and stable until each rd_valid.
- Wrap: read at 0xFFFF -> rd_addr 0x7FFF, then after tx_ready 0x0000.
- Abort:
  - Stimulus: end while rd_busy and rd_valid delayed 20 cycles; new start with 0x80,0x05 before rd_valid.
  - Required: stale data discarded; rd_en for 0x0005 only after the first rd_valid; qspi_tx_valid shows the 0x0005 data.
- Timeout: RD_TIMEOUT=16, rd_valid never asserted -> qspi_tx_data=0xEE after 16 cycles and timeout_count=1.
- Underrun/reset:
  - Stimulus: tx_ready with tx_valid=0 repeated 300 times.
  - Required: underrun_count saturates at 255.
  - Stimulus: then rst_n=0 for one cycle.
  - Required: all outputs and counters return to 0.

Source files
------------

// File: rtl/mgmt_qspi_bridge.sv
// Bridges the QSPI device-mode byte PHY to the management register bus.
// Frames are a 2-byte address (bit 15 = read flag) followed by data bytes; address auto-increments.
module mgmt_qspi_bridge #(
  parameter int unsigned RD_TIMEOUT = 1024,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 qspi_start,
  input  logic                 qspi_end,
  input  logic                 qspi_rx_valid,
  input  logic [7:0]           qspi_rx_data,
  input  logic                 qspi_tx_ready,
  output logic                 qspi_tx_valid,
  output logic [7:0]           qspi_tx_data,
  output logic                 rd_en,
  output logic [15:0]          rd_addr,
  input  logic                 rd_valid,
  input  logic [7:0]           rd_data,
  output logic                 wr_en,
  output logic [15:0]          wr_addr,
  output logic [7:0]           wr_data,
  output logic [CNT_WIDTH-1:0] underrun_count,
  output logic [CNT_WIDTH-1:0] timeout_count
);

  localparam int unsigned TW = $clog2(RD_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    WRITE,
    READ
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          addr_q, addr_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 rd_en_q, rd_en_d;
  logic [15:0]          rd_addr_q, rd_addr_d;
  logic                 rd_busy_q, rd_busy_d;
  logic                 rd_discard_q, rd_discard_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 wr_en_q, wr_en_d;
  logic [15:0]          wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic [CNT_WIDTH-1:0] underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0] timeout_q, timeout_d;

  logic abort;
  logic timeout_hit;
  logic complete;
  logic req;

  function automatic logic [15:0] addr_inc(input logic [15:0] a);
    return {1'b0, a[14:0] + 15'd1};
  endfunction

  assign abort       = qspi_start | qspi_end;
  assign timeout_hit = rd_busy_q & ~rd_valid & (timer_q == TW'(RD_TIMEOUT - 1));
  assign complete    = rd_busy_q & (rd_valid | timeout_hit);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_busy_d    = rd_busy_q & ~complete;
    rd_discard_d = rd_discard_q;
    rd_pend_d    = rd_pend_q & ~abort;
    timer_d      = (rd_busy_q && !complete) ? timer_q + TW'(1) : '0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    underrun_d   = underrun_q;
    timeout_d    = timeout_q;
    req          = 1'b0;

    if (complete) begin
      rd_discard_d = 1'b0;
    end else if (abort && rd_busy_q) begin
      rd_discard_d = 1'b1;
    end

    if (timeout_hit) begin
      rd_addr_d = '0;
      if (timeout_q != '1) timeout_d = timeout_q + CNT_WIDTH'(1);
    end

    if (qspi_tx_ready && !tx_valid_q && underrun_q != '1) begin
      underrun_d = underrun_q + CNT_WIDTH'(1);
    end

    // Start/end take precedence; any read completing in that cycle is dropped.
    if (qspi_start) begin
      state_d    = ADDR_HI;
      tx_valid_d = 1'b0;
    end else if (qspi_end) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        ADDR_HI: begin
          if (qspi_rx_valid) begin
            addr_d[15:8] = qspi_rx_data;
            state_d      = ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (qspi_rx_valid) begin
            addr_d = {1'b0, addr_q[14:8], qspi_rx_data};
            if (addr_q[15]) begin
              state_d = READ;
              req     = 1'b1;
            end else begin
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          if (qspi_rx_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {1'b0, addr_q[14:0]};
            wr_data_d = qspi_rx_data;
            addr_d    = addr_inc(addr_q);
          end
        end
        READ: begin
          if (complete && !rd_discard_q) begin
            tx_data_d  = rd_valid ? rd_data : 8'hEE;
            tx_valid_d = 1'b1;
            addr_d     = addr_inc(addr_q);
          end
          if (qspi_tx_ready && tx_valid_q) begin
            tx_valid_d = 1'b0;
            req        = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A request made while a discarded read drains waits in rd_pend until the bus frees.
    if ((req || rd_pend_d) && !rd_busy_q) begin
      rd_en_d   = 1'b1;
      rd_addr_d = {1'b0, addr_d[14:0]};
      rd_busy_d = 1'b1;
      timer_d   = '0;
      rd_pend_d = 1'b0;
    end else if (req) begin
      rd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_busy_q    <= 1'b0;
      rd_discard_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      timer_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      underrun_q   <= '0;
      timeout_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_busy_q    <= rd_busy_d;
      rd_discard_q <= rd_discard_d;
      rd_pend_q    <= rd_pend_d;
      timer_q      <= timer_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      underrun_q   <= underrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign qspi_tx_valid  = tx_valid_q;
  assign qspi_tx_data   = tx_data_q;
  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign underrun_count = underrun_q;
  assign timeout_count  = timeout_q;

endmodule
